c1541_track_ctrl: RTL and testbench
===================================

C1541_TRACK_CTRL -- requirements
Module: c1541_track_ctrl

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 32000, meaning head-settle delay in clk32 cycles after a half_track change (1 ms).
REQ-002 SHALL have port clk32  in  1  sole clock; every register updates on its rising edge.
REQ-003 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have ports img_mounted in 1 (1-cycle pulse: new image) and img_readonly in 1 (suppress write-back).
REQ-005 SHALL have ports half_track in 7 (head position) and mtr in 1 (spindle motor on).
REQ-006 SHALL have GCR-side ports gcr_addr in 13, gcr_di in 8, gcr_we in 1, gcr_do out 8, ram_ready out 1.
REQ-007 SHALL have SD-side ports sd_lba out 32, sd_rd out 1, sd_wr out 1, sd_ack in 1, sd_buff_addr in 9, sd_buff_dout in 8, sd_buff_wr in 1, sd_buff_din out 8.
REQ-008 SHALL have track-buffer RAM ports buf_addr out 13, buf_di out 8, buf_we out 1, buf_do in 8 (1-cycle read latency).
REQ-009 SHALL have port busy out 1, high in every state except READY and IDLE.

Function
REQ-010 SHALL implement states IDLE, SETTLE, FLUSH, LOAD, READY.
REQ-011 Track index SHALL be trk = min(half_track[6:1], 41); trk latched on entry to FLUSH/LOAD; buffer holds 16 sectors of 512 bytes.
REQ-012 sd_lba SHALL equal {22'b0, trk_latched[5:0], sector[3:0]}, sector a 4-bit counter cleared on entry to FLUSH and LOAD.
REQ-013 IDLE -> SETTLE when a valid image is mounted and mtr=1; mount validity is set by img_mounted and cleared only by reset.
REQ-014 SETTLE: counter loads SETTLE_CYCLES-1 on entry and on every half_track change; at 0, go to FLUSH if dirty and !img_readonly, else LOAD if trk differs from loaded track or buffer invalid, else READY.
REQ-015 FLUSH/LOAD handshake: raise sd_wr/sd_rd and hold it until the cycle after sd_ack rises, then drop it; the sector completes on sd_ack falling.
REQ-016 On sector completion, sector increments; after sector 15 completes, FLUSH -> LOAD (dirty cleared) and LOAD -> READY (loaded track := trk_latched, buffer valid).
REQ-017 LOAD: buf_addr = {sector, sd_buff_addr}, buf_di = sd_buff_dout, buf_we = sd_buff_wr & sd_ack.
REQ-018 FLUSH: buf_addr = {sector, sd_buff_addr}, buf_we = 0, sd_buff_din = buf_do.
REQ-019 READY: buf_addr = gcr_addr, buf_di = gcr_di, buf_we = gcr_we, ram_ready = 1; gcr_we=1 sets dirty.
REQ-020 ram_ready SHALL be 0 in all states but READY, and gcr_we SHALL be ignored outside READY.
REQ-021 gcr_do SHALL equal buf_do in every state.
REQ-022 READY -> SETTLE on half_track change; READY -> FLUSH on mtr falling when dirty and !img_readonly, else READY -> IDLE on mtr falling.
REQ-023 img_mounted in any state SHALL abort any transfer (sd_rd=sd_wr=0), clear dirty, invalidate the buffer, and go to SETTLE if mtr=1, else IDLE.
REQ-024 half_track changes during FLUSH or LOAD SHALL NOT abort the operation; after it finishes, the controller re-enters SETTLE if trk differs.
REQ-025 After FLUSH entered from mtr falling, LOAD SHALL be skipped and the controller SHALL go to IDLE.
REQ-026 Writes to the same cycle as leaving READY SHALL still be committed and counted dirty.

Reset
REQ-027 On reset: state=IDLE; sd_rd=sd_wr=0; ram_ready=0; buf_we=0; busy=0; dirty=0; buffer invalid; mount invalid; sector=0; sd_lba=0.
REQ-028 Reset asserted mid-transfer SHALL drop sd_rd/sd_wr on the next edge without waiting for sd_ack.

Verification
REQ-029 Cold load: SETTLE_CYCLES=4, img_mounted, mtr=1, half_track=36 -> sixteen sd_rd requests with sd_lba 0x120..0x12F, then ram_ready=1.
REQ-030 Dirty step: in READY write gcr_addr=0x0005 data 0xA5, then half_track=38 -> FLUSH lba 0x120..0x12F with byte 0xA5 at sector 0 offset 5, then LOAD 0x130..0x13F.
REQ-031 Readonly: img_readonly=1, write, step -> no sd_wr, LOAD only.
REQ-032 Half-step: half_track 36 -> 37 -> settle, no LOAD (same trk), ram_ready returns.
REQ-033 Motor off dirty: mtr falls in READY after write -> 16 sd_wr, then IDLE, ram_ready=0, no sd_rd.
REQ-034 Abort: reset or img_mounted during LOAD sector 7 -> sd_rd=0 next cycle, buffer invalid, later full reload from sector 0.

Source files
------------

// File: rtl/c1541_track_ctrl.sv
// c1541_track_ctrl
//   Keeps one whole GCR track (16 sectors x 512 bytes) in an external
//   track-buffer RAM. It loads the track from the SD image when the head
//   settles on a new track and writes a modified track back before it
//   leaves that track or the motor stops.
//
// Ports
//   clk32, reset        sole clock; synchronous active-high reset
//   img_mounted         1-cycle pulse: a new image is mounted
//   img_readonly        suppress write-back of modified tracks
//   half_track, mtr     head position (half tracks) and spindle motor
//   gcr_*, ram_ready    GCR engine access to the buffer (READY state only)
//   sd_*                sector-based SD image interface (lba/rd/wr/ack, byte bus)
//   buf_*               track-buffer RAM port, buf_do has 1-cycle latency
//   busy                high while settling or transferring
module c1541_track_ctrl #(
    parameter int SETTLE_CYCLES = 32000
) (
    input  logic        clk32,
    input  logic        reset,
    input  logic        img_mounted,
    input  logic        img_readonly,
    input  logic [6:0]  half_track,
    input  logic        mtr,
    input  logic [12:0] gcr_addr,
    input  logic [7:0]  gcr_di,
    input  logic        gcr_we,
    output logic [7:0]  gcr_do,
    output logic        ram_ready,
    output logic [31:0] sd_lba,
    output logic        sd_rd,
    output logic        sd_wr,
    input  logic        sd_ack,
    input  logic [8:0]  sd_buff_addr,
    input  logic [7:0]  sd_buff_dout,
    input  logic        sd_buff_wr,
    output logic [7:0]  sd_buff_din,
    output logic [12:0] buf_addr,
    output logic [7:0]  buf_di,
    output logic        buf_we,
    input  logic [7:0]  buf_do,
    output logic        busy
);
    localparam int               CNT_W       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [5:0]       MAX_TRK     = 6'd41;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        FLUSH,
        LOAD,
        READY
    } state_t;

    state_t           state;
    state_t           state_nx;

    logic             mount_ok;       // a valid image has been mounted since reset
    logic             dirty;          // buffer modified since it was loaded
    logic             buf_valid;      // buffer holds loaded_trk completely
    logic             flush_to_idle;  // current FLUSH was caused by the motor stopping
    logic [5:0]       loaded_trk;
    logic [5:0]       trk_latched;
    logic [3:0]       sector;
    logic [CNT_W-1:0] settle_cnt;
    logic             req_q;          // sd_rd / sd_wr request, qualified by state
    logic             ack_q;
    logic             mtr_q;
    logic [6:0]       ht_q;

    logic [5:0]       trk;
    logic             ht_changed;
    logic             mtr_fall;
    logic             xfer;
    logic             sector_done;
    logic             last_done;
    logic             dirty_now;

    // Track index from the head position, clamped to the last track an image can hold.
    assign trk         = (half_track[6:1] > MAX_TRK) ? MAX_TRK : half_track[6:1];
    assign ht_changed  = (half_track != ht_q);
    assign mtr_fall    = mtr_q & ~mtr;
    assign xfer        = (state == FLUSH) || (state == LOAD);
    // A sector is finished when the SD side drops ack after the request was withdrawn.
    assign sector_done = xfer & ack_q & ~sd_ack & ~req_q;
    assign last_done   = sector_done & (sector == 4'd15);
    // A GCR write in the very cycle READY is left still has to be written back.
    assign dirty_now   = dirty | ((state == READY) & gcr_we);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: registers are assigned with <= so every always_ff samples the
    // values from before the edge, independent of block ordering.
    always_ff @(posedge clk32) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // NOTE: state_nx gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nx = state;
        if (img_mounted) begin
            state_nx = mtr ? SETTLE : IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (mount_ok && mtr) state_nx = SETTLE;
                end
                SETTLE: begin
                    if (!ht_changed && settle_cnt == '0) begin
                        if (dirty && !img_readonly)              state_nx = FLUSH;
                        else if (trk != loaded_trk || !buf_valid) state_nx = LOAD;
                        else                                     state_nx = READY;
                    end
                end
                FLUSH: begin
                    if (last_done) state_nx = flush_to_idle ? IDLE : LOAD;
                end
                LOAD: begin
                    // The head may have moved during the load; settle again if so.
                    if (last_done) state_nx = (trk != trk_latched) ? SETTLE : READY;
                end
                READY: begin
                    if (ht_changed)    state_nx = SETTLE;
                    else if (mtr_fall) state_nx = (dirty_now && !img_readonly) ? FLUSH : IDLE;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk32) begin
        if (reset) begin
            mount_ok      <= 1'b0;
            dirty         <= 1'b0;
            buf_valid     <= 1'b0;
            flush_to_idle <= 1'b0;
            loaded_trk    <= '0;
            trk_latched   <= '0;
            sector        <= '0;
            settle_cnt    <= '0;
            req_q         <= 1'b0;
            ack_q         <= 1'b0;
            mtr_q         <= 1'b0;
            ht_q          <= half_track;
        end else begin
            ack_q <= sd_ack;
            mtr_q <= mtr;
            ht_q  <= half_track;

            if (state_nx == SETTLE && (state != SETTLE || ht_changed || img_mounted)) begin
                settle_cnt <= SETTLE_LOAD;
            end else if (settle_cnt != '0) begin
                settle_cnt <= settle_cnt - 1'b1;
            end

            if (img_mounted) begin
                // A new disk invalidates everything and abandons any transfer.
                mount_ok      <= 1'b1;
                dirty         <= 1'b0;
                buf_valid     <= 1'b0;
                flush_to_idle <= 1'b0;
                req_q         <= 1'b0;
            end else begin
                if (state == READY && gcr_we) dirty <= 1'b1;

                if (state == READY && state_nx == FLUSH) flush_to_idle <= 1'b1;

                if (state_nx == FLUSH && state != FLUSH) begin
                    // Write-back targets the track the buffer was loaded from.
                    trk_latched <= loaded_trk;
                    sector      <= '0;
                    req_q       <= 1'b1;
                end else if (state_nx == LOAD && state != LOAD) begin
                    trk_latched <= trk;
                    sector      <= '0;
                    req_q       <= 1'b1;
                    buf_valid   <= 1'b0;
                end else if (xfer) begin
                    if (req_q && sd_ack) req_q <= 1'b0;
                    if (sector_done) begin
                        sector <= sector + 4'd1;
                        if (sector != 4'd15) req_q <= 1'b1;
                    end
                end

                if (state == FLUSH && last_done) begin
                    dirty         <= 1'b0;
                    flush_to_idle <= 1'b0;
                end

                if (state == LOAD && last_done) begin
                    loaded_trk <= trk_latched;
                    buf_valid  <= 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Buffer port steering
    // ------------------------------------------------------------------
    always_comb begin
        buf_addr  = gcr_addr;
        buf_di    = gcr_di;
        buf_we    = 1'b0;
        ram_ready = 1'b0;
        unique case (state)
            LOAD: begin
                buf_addr = {sector, sd_buff_addr};
                buf_di   = sd_buff_dout;
                buf_we   = sd_buff_wr & sd_ack;
            end
            FLUSH: begin
                buf_addr = {sector, sd_buff_addr};
            end
            READY: begin
                buf_we    = gcr_we;
                ram_ready = 1'b1;
            end
            default: ;
        endcase
    end

    assign gcr_do      = buf_do;
    assign sd_buff_din = buf_do;
    assign sd_rd       = req_q & (state == LOAD);
    assign sd_wr       = req_q & (state == FLUSH);
    assign sd_lba      = {22'd0, trk_latched, sector};
    assign busy        = (state != READY) && (state != IDLE);

endmodule

// File: tb/tb_c1541_track_ctrl.sv
// tb_c1541_track_ctrl
//   Directed bench for c1541_track_ctrl. Models the track-buffer RAM and the
//   SD host; expected SD requests are queued when stimulus is applied and
//   checked as the controller issues them. A shadow copy of the buffer
//   contents predicts GCR read data and write-back data.
module tb_c1541_track_ctrl;

    typedef struct packed {
        logic        wr;
        logic [31:0] lba;
    } sb_t;

    logic        clk32 = 1'b0;
    logic        reset;
    logic        img_mounted;
    logic        img_readonly;
    logic [6:0]  half_track;
    logic        mtr;
    logic [12:0] gcr_addr;
    logic [7:0]  gcr_di;
    logic        gcr_we;
    logic [7:0]  gcr_do;
    logic        ram_ready;
    logic [31:0] sd_lba;
    logic        sd_rd;
    logic        sd_wr;
    logic        sd_ack;
    logic [8:0]  sd_buff_addr;
    logic [7:0]  sd_buff_dout;
    logic        sd_buff_wr;
    logic [7:0]  sd_buff_din;
    logic [12:0] buf_addr;
    logic [7:0]  buf_di;
    logic        buf_we;
    logic [7:0]  buf_do;
    logic        busy;

    logic [7:0]  ram       [0:8191];
    logic [7:0]  model_mem [0:8191];
    sb_t         sb_q [$];

    int          n_cmp = 0;
    int          n_err = 0;
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    logic        sd_rd_d = 1'b0;
    logic        sd_wr_d = 1'b0;
    logic [7:0]  flush_b5;

    c1541_track_ctrl #(.SETTLE_CYCLES(4)) dut (
        .clk32        (clk32),
        .reset        (reset),
        .img_mounted  (img_mounted),
        .img_readonly (img_readonly),
        .half_track   (half_track),
        .mtr          (mtr),
        .gcr_addr     (gcr_addr),
        .gcr_di       (gcr_di),
        .gcr_we       (gcr_we),
        .gcr_do       (gcr_do),
        .ram_ready    (ram_ready),
        .sd_lba       (sd_lba),
        .sd_rd        (sd_rd),
        .sd_wr        (sd_wr),
        .sd_ack       (sd_ack),
        .sd_buff_addr (sd_buff_addr),
        .sd_buff_dout (sd_buff_dout),
        .sd_buff_wr   (sd_buff_wr),
        .sd_buff_din  (sd_buff_din),
        .buf_addr     (buf_addr),
        .buf_di       (buf_di),
        .buf_we       (buf_we),
        .buf_do       (buf_do),
        .busy         (busy)
    );

    always #5 clk32 = ~clk32;

    // Track-buffer RAM, read-first, one cycle read latency.
    always @(posedge clk32) begin
        if (buf_we) ram[buf_addr] <= buf_di;
        buf_do <= ram[buf_addr];
    end

    // Count SD requests (rising edges) to prove that none were issued.
    always @(posedge clk32) begin
        sd_rd_d <= sd_rd;
        sd_wr_d <= sd_wr;
        if (sd_rd && !sd_rd_d) rd_cnt <= rd_cnt + 1;
        if (sd_wr && !sd_wr_d) wr_cnt <= wr_cnt + 1;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] pat(input logic [31:0] lba, input int i);
        logic [8:0] a;
        a = i[8:0];
        return (lba[7:0] * 8'd3) ^ a[7:0] ^ (a[8] ? 8'h5A : 8'h00);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_track(input logic wr, input int trk, input int count);
        for (int s = 0; s < count; s++) begin
            sb_t e;
            e.wr  = wr;
            e.lba = 32'(trk * 16 + s);
            sb_q.push_back(e);
        end
    endtask

    task automatic pulse_mount();
        img_mounted = 1'b1;
        @(negedge clk32);
        img_mounted = 1'b0;
    endtask

    // Pop the next expected request and wait (bounded) for the DUT to raise it.
    task automatic get_req(output sb_t e, output bit seen);
        int t;
        t    = 0;
        e    = '0;
        check("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) e = sb_q.pop_front();
        while (!(sd_rd || sd_wr) && t < 400) begin
            @(negedge clk32);
            t++;
        end
        seen = sd_rd || sd_wr;
        check("req_seen", 32'(seen), 32'd1);
        if (seen) begin
            check("req_dir", {30'd0, sd_wr, sd_rd}, e.wr ? 32'd2 : 32'd1);
            check("req_lba", sd_lba, e.lba);
        end
    endtask

    // Act as the SD host for one sector, moving nbytes bytes.
    task automatic sd_serve(input int nbytes);
        sb_t        e;
        bit         seen;
        int         bad;
        logic [7:0] d;
        get_req(e, seen);
        if (seen) begin
            bad    = 0;
            sd_ack = 1'b1;
            for (int i = 0; i < nbytes; i++) begin
                sd_buff_addr = i[8:0];
                if (!e.wr) begin
                    d            = pat(e.lba, i);
                    sd_buff_dout = d;
                    sd_buff_wr   = 1'b1;
                    model_mem[{e.lba[3:0], i[8:0]}] = d;
                end
                @(negedge clk32);
                if (i == 0) check("req_drop", {30'd0, sd_rd, sd_wr}, 32'd0);
                if (e.wr) begin
                    if (sd_buff_din !== model_mem[{e.lba[3:0], i[8:0]}]) bad++;
                    if (e.lba[3:0] == 4'd0 && i == 5) flush_b5 = sd_buff_din;
                end
            end
            sd_buff_wr = 1'b0;
            sd_ack     = 1'b0;
            if (e.wr) check("flush_data_bad_bytes", 32'(bad), 32'd0);
            @(negedge clk32);
        end
    endtask

    task automatic wait_ready(input string tag);
        int t;
        t = 0;
        while (ram_ready !== 1'b1 && t < 400) begin
            @(negedge clk32);
            t++;
        end
        check(tag, {31'd0, ram_ready}, 32'd1);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic gcr_write(input logic [12:0] a, input logic [7:0] d);
        gcr_addr     = a;
        gcr_di       = d;
        gcr_we       = 1'b1;
        model_mem[a] = d;
        @(negedge clk32);
        gcr_we       = 1'b0;
    endtask

    task automatic gcr_read(input string tag, input logic [12:0] a);
        gcr_addr = a;
        @(negedge clk32);
        check(tag, {24'd0, gcr_do}, {24'd0, model_mem[a]});
    endtask

    initial begin
        int  rd_mark;
        int  wr_mark;
        sb_t e;
        bit  seen;

        reset        = 1'b1;
        img_mounted  = 1'b0;
        img_readonly = 1'b0;
        half_track   = 7'd0;
        mtr          = 1'b0;
        gcr_addr     = '0;
        gcr_di       = '0;
        gcr_we       = 1'b0;
        sd_ack       = 1'b0;
        sd_buff_addr = '0;
        sd_buff_dout = '0;
        sd_buff_wr   = 1'b0;
        flush_b5     = '0;

        // Reset state
        repeat (3) @(negedge clk32);
        check("rst_sd_rd",     {31'd0, sd_rd},     32'd0);
        check("rst_sd_wr",     {31'd0, sd_wr},     32'd0);
        check("rst_ram_ready", {31'd0, ram_ready}, 32'd0);
        check("rst_busy",      {31'd0, busy},      32'd0);
        check("rst_buf_we",    {31'd0, buf_we},    32'd0);
        check("rst_sd_lba",    sd_lba,             32'd0);
        reset = 1'b0;

        // Cold load of track 18
        half_track = 7'd36;
        mtr        = 1'b1;
        push_track(1'b0, 18, 16);
        pulse_mount();
        check("cold_busy",  {31'd0, busy},      32'd1);
        check("cold_ready", {31'd0, ram_ready}, 32'd0);
        repeat (16) sd_serve(512);
        wait_ready("cold_ready_up");
        gcr_read("cold_gcr_rd", 13'h0607);

        // Dirty step: flush track 18 then load track 19
        gcr_write(13'h0005, 8'hA5);
        gcr_read("dirty_gcr_rd", 13'h0005);
        half_track = 7'd38;
        push_track(1'b1, 18, 16);
        push_track(1'b0, 19, 16);
        repeat (16) sd_serve(512);
        check("flush_s0_o5", {24'd0, flush_b5}, 32'h0000_00A5);
        repeat (16) sd_serve(16);
        wait_ready("step_ready");
        gcr_read("step_gcr_rd", 13'h0203);

        // Read-only image: modified track is not written back
        img_readonly = 1'b1;
        gcr_write(13'h0010, 8'h3C);
        wr_mark    = wr_cnt;
        half_track = 7'd40;
        push_track(1'b0, 20, 16);
        repeat (16) sd_serve(512);
        wait_ready("ro_ready");
        check("ro_no_write", 32'(wr_cnt), 32'(wr_mark));

        // Half step on the same track: settle, no transfer
        rd_mark    = rd_cnt;
        half_track = 7'd41;
        @(negedge clk32);
        check("half_busy",  {31'd0, busy},      32'd1);
        check("half_ready", {31'd0, ram_ready}, 32'd0);
        wait_ready("half_ready_up");
        check("half_no_rd", 32'(rd_cnt), 32'(rd_mark));
        check("half_no_wr", 32'(wr_cnt), 32'(wr_mark));

        // Motor off with dirty buffer: write back, then idle without loading
        img_readonly = 1'b0;
        gcr_write(13'h0207, 8'h77);
        rd_mark = rd_cnt;
        mtr     = 1'b0;
        push_track(1'b1, 20, 16);
        repeat (16) sd_serve(512);
        repeat (4) @(negedge clk32);
        check("moff_ready", {31'd0, ram_ready}, 32'd0);
        check("moff_busy",  {31'd0, busy},      32'd0);
        check("moff_no_rd", 32'(rd_cnt), 32'(rd_mark));

        // Motor back on: buffer still valid and clean, no load
        mtr = 1'b1;
        wait_ready("mon_ready");
        check("mon_no_rd", 32'(rd_cnt), 32'(rd_mark));

        // Abort by img_mounted during LOAD sector 7
        push_track(1'b0, 20, 8);
        pulse_mount();
        repeat (7) sd_serve(16);
        get_req(e, seen);
        img_mounted = 1'b1;
        @(negedge clk32);
        img_mounted = 1'b0;
        check("abort_mnt_rd",   {31'd0, sd_rd}, 32'd0);
        check("abort_mnt_busy", {31'd0, busy},  32'd1);
        push_track(1'b0, 20, 16);
        repeat (16) sd_serve(16);
        wait_ready("abort_mnt_ready");
        gcr_read("abort_mnt_gcr_rd", 13'h0E05);

        // Abort by reset during LOAD sector 7
        push_track(1'b0, 20, 8);
        pulse_mount();
        repeat (7) sd_serve(16);
        get_req(e, seen);
        reset = 1'b1;
        @(negedge clk32);
        reset = 1'b0;
        check("abort_rst_rd",     {31'd0, sd_rd},     32'd0);
        check("abort_rst_busy",   {31'd0, busy},      32'd0);
        check("abort_rst_ready",  {31'd0, ram_ready}, 32'd0);
        check("abort_rst_lba",    sd_lba,             32'd0);
        rd_mark = rd_cnt;
        repeat (10) @(negedge clk32);
        check("rst_unmounted_busy", {31'd0, busy}, 32'd0);
        check("rst_unmounted_rd",   32'(rd_cnt), 32'(rd_mark));
        push_track(1'b0, 20, 16);
        pulse_mount();
        repeat (16) sd_serve(16);
        wait_ready("abort_rst_ready_up");
        gcr_read("abort_rst_gcr_rd", 13'h0E05);

        // Head beyond the last track clamps to track 41
        half_track = 7'd100;
        push_track(1'b0, 41, 16);
        repeat (16) sd_serve(16);
        wait_ready("clamp_ready");
        gcr_read("clamp_gcr_rd", 13'h1E0A);

        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
